// File: rtl/iecdrv_gcr_stream.sv
// iecdrv_gcr_stream: drive-side bit-cell engine for the track bit memory.
// Walks the track one bit cell per speed-zone period. In read mode it detects
// SYNC and assembles GCR bytes; in write mode it serialises bytes into the track.
module iecdrv_gcr_stream #(
    parameter int unsigned ADDRWIDTH = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   enable,
    input  logic [1:0]             speed_zone,
    input  logic                   mode,
    input  logic [ADDRWIDTH+2:0]   track_len,
    input  logic [7:0]             wr_byte,
    output logic [ADDRWIDTH+2:0]   mem_addr,
    output logic                   mem_we,
    output logic                   mem_wdata,
    input  logic                   mem_rdata,
    output logic [7:0]             rd_byte,
    output logic                   byte_ready,
    output logic                   sync_n
);

    localparam int unsigned BW       = ADDRWIDTH + 3;
    localparam int unsigned BW1      = BW + 1;
    localparam int unsigned CW       = 6;
    localparam logic [3:0]  ONES_SAT = 4'd10;

    // Registered state
    logic [CW-1:0] cell_cnt;
    logic [1:0]    zone_q;
    logic          mode_q;
    logic          rd_p1;
    logic          rd_p2;
    logic [2:0]    bit_cnt;
    logic [3:0]    ones;
    logic [7:0]    rd_shift;
    logic [7:0]    wr_shift;

    // Next-state values
    logic [2:0]    bit_cnt_d;
    logic [3:0]    ones_d;
    logic [7:0]    rd_shift_d;
    logic [7:0]    wr_shift_d;
    logic [7:0]    rd_byte_d;
    logic          mem_we_d;
    logic          mem_wdata_d;
    logic          byte_ready_d;
    logic          sync_n_d;

    // Combinational decode
    logic          tick_c;
    logic          cell_start_c;
    logic          cell_end_c;
    logic [CW-1:0] cell_last_c;
    logic [BW:0]   len_eff_c;
    logic [BW:0]   addr_inc_c;
    logic [BW-1:0] addr_next_c;
    logic          mode_chg_c;
    logic          rd_go_c;
    logic [2:0]    bit_base_c;
    logic [7:0]    wr_src_c;
    logic [7:0]    rd_new_c;
    logic [3:0]    ones_inc_c;
    logic          sync_hit_c;

    // Cell timing and address-wrap decode
    always_comb begin
        tick_c       = enable & ce;
        cell_start_c = tick_c & (cell_cnt == '0);
        // last tick index of a cell is 4*(16-zone)-1
        cell_last_c  = CW'(6'd63 - {2'b00, zone_q, 2'b00});
        cell_end_c   = tick_c & (cell_cnt == cell_last_c);
        // zero length means the full bit address space
        len_eff_c    = (track_len == '0) ? {1'b1, BW'(0)} : {1'b0, track_len};
        addr_inc_c   = {1'b0, mem_addr} + BW1'(1);
        addr_next_c  = (addr_inc_c >= len_eff_c) ? '0 : addr_inc_c[BW-1:0];
    end

    // Bit-level decode for the write serialiser and read assembler
    always_comb begin
        mode_chg_c = cell_start_c & (mode != mode_q);
        rd_go_c    = enable & rd_p2;
        bit_base_c = mode_chg_c ? 3'd0 : bit_cnt;
        // entering write mode starts from a freshly loaded byte
        wr_src_c   = (mode_chg_c & ~mode) ? wr_byte : wr_shift;
        rd_new_c   = {rd_shift[6:0], mem_rdata};
        if (!mem_rdata) begin
            ones_inc_c = '0;
        end else if (ones == ONES_SAT) begin
            ones_inc_c = ONES_SAT;
        end else begin
            ones_inc_c = ones + 4'd1;
        end
        sync_hit_c = mem_rdata & (ones_inc_c == ONES_SAT);
    end

    // Cell tick counter with per-cell zone and mode capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_cnt <= '0;
            zone_q   <= '0;
            mode_q   <= 1'b1;
        end else begin
            if (cell_end_c) begin
                cell_cnt <= '0;
            end else if (tick_c) begin
                cell_cnt <= cell_cnt + CW'(1);
            end
            if (cell_start_c) begin
                zone_q <= speed_zone;
                mode_q <= mode;
            end
        end
    end

    // Track address advances once per completed cell
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
        end else if (cell_end_c) begin
            mem_addr <= addr_next_c;
        end
    end

    // Two-stage read-latency pipeline; frozen while the drive is disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_p1 <= 1'b0;
            rd_p2 <= 1'b0;
        end else if (enable) begin
            rd_p1 <= cell_start_c & mode;
            rd_p2 <= rd_p1;
        end
    end

    // Next-state for bit counter, shifters and strobes
    always_comb begin
        bit_cnt_d    = bit_cnt;
        ones_d       = ones;
        rd_shift_d   = rd_shift;
        wr_shift_d   = wr_shift;
        rd_byte_d    = rd_byte;
        mem_wdata_d  = mem_wdata;
        mem_we_d     = 1'b0;
        byte_ready_d = 1'b0;
        sync_n_d     = enable ? sync_n : 1'b1;

        if (cell_start_c) begin
            if (!mode) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = wr_src_c[7];
                ones_d      = '0;
                sync_n_d    = 1'b1;
                bit_cnt_d   = bit_base_c + 3'd1;
                if (bit_base_c == 3'd7) begin
                    wr_shift_d   = wr_byte;
                    byte_ready_d = 1'b1;
                end else begin
                    wr_shift_d = {wr_src_c[6:0], 1'b0};
                end
            end else if (mode_chg_c) begin
                bit_cnt_d = '0;
            end
        end

        if (rd_go_c) begin
            rd_shift_d = rd_new_c;
            ones_d     = ones_inc_c;
            if (sync_hit_c) begin
                sync_n_d  = 1'b0;
                bit_cnt_d = '0;
            end else begin
                sync_n_d  = 1'b1;
                bit_cnt_d = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rd_byte_d    = rd_new_c;
                    byte_ready_d = 1'b1;
                end
            end
        end
    end

    // Register bit-level state and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            ones       <= '0;
            rd_shift   <= '0;
            wr_shift   <= '0;
            rd_byte    <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= 1'b0;
            byte_ready <= 1'b0;
            sync_n     <= 1'b1;
        end else begin
            bit_cnt    <= bit_cnt_d;
            ones       <= ones_d;
            rd_shift   <= rd_shift_d;
            wr_shift   <= wr_shift_d;
            rd_byte    <= rd_byte_d;
            mem_we     <= mem_we_d;
            mem_wdata  <= mem_wdata_d;
            byte_ready <= byte_ready_d;
            sync_n     <= sync_n_d;
        end
    end

endmodule

// File: tb/tb_iecdrv_gcr_stream.sv
// tb_iecdrv_gcr_stream: randomized bench with a cell-level reference model.
module tb_iecdrv_gcr_stream;

    localparam int unsigned AW  = 13;
    localparam int unsigned BW  = AW + 3;
    localparam int          TRK = 1 << BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic          enable;
    logic [1:0]    speed_zone;
    logic          mode;
    logic [BW-1:0] track_len;
    logic [7:0]    wr_byte;
    logic [BW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_wdata;
    logic          mem_rdata = 1'b0;
    logic [7:0]    rd_byte;
    logic          byte_ready;
    logic          sync_n;

    always #5 clk = ~clk;

    iecdrv_gcr_stream #(.ADDRWIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .enable     (enable),
        .speed_zone (speed_zone),
        .mode       (mode),
        .track_len  (track_len),
        .wr_byte    (wr_byte),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rd_byte    (rd_byte),
        .byte_ready (byte_ready),
        .sync_n     (sync_n)
    );

    // Track memory written by the DUT, two-clock read latency
    bit   trk     [TRK];
    bit   exp_trk [TRK];
    logic rd_p1 = 1'b0;
    always @(posedge clk) begin
        if (mem_we) trk[mem_addr] <= mem_wdata;
        rd_p1     <= trk[mem_addr];
        mem_rdata <= rd_p1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected outputs after the coming clock edge
    int m_addr, m_we, m_wdata, m_rd, m_br, m_sync;
    int m_tick, m_zone, m_mode, m_pend, m_ones, m_pos, m_hist, m_wbyte;
    int m_cells = 0;
    int ce_gap = 0;

    // Observation counters for directed checks
    int seen_q[$];
    int br_cnt, we_cnt, sync_falls, sync_prev;

    task automatic model_reset();
        m_addr = 0; m_we = 0; m_wdata = 0; m_rd = 0; m_br = 0; m_sync = 1;
        m_tick = 0; m_zone = 0; m_mode = 1; m_pend = 0;
        m_ones = 0; m_pos = 0; m_hist = 0; m_wbyte = 0;
    endtask

    task automatic read_cell(input int b);
        m_ones = b ? ((m_ones < 10) ? m_ones + 1 : 10) : 0;
        m_hist = ((m_hist << 1) | b) & 255;
        if (b == 1 && m_ones == 10) begin
            m_sync = 0;
            m_pos  = 0;
        end else begin
            m_sync = 1;
            m_pos  = (m_pos + 1) % 8;
            if (m_pos == 0) begin
                m_rd = m_hist;
                m_br = 1;
            end
        end
    endtask

    task automatic start_cell();
        m_zone = int'(speed_zone);
        if (int'(mode) != m_mode) begin
            m_pos = 0;
            if (mode == 1'b0) m_wbyte = int'(wr_byte);
        end
        m_mode = int'(mode);
        if (m_mode == 0) begin
            m_we    = 1;
            m_wdata = (m_wbyte >> (7 - m_pos)) & 1;
            exp_trk[m_addr] = m_wdata[0];
            m_ones  = 0;
            m_sync  = 1;
            m_pos   = (m_pos + 1) % 8;
            if (m_pos == 0) begin
                m_br    = 1;
                m_wbyte = int'(wr_byte);
            end
        end else begin
            m_pend = 2;
        end
    endtask

    task automatic model_step();
        int lenv;
        m_we = 0;
        m_br = 0;
        if (!enable) begin
            m_sync = 1;
            return;
        end
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) read_cell(int'(exp_trk[m_addr]));
        end
        if (ce) begin
            if (m_tick == 0) start_cell();
            m_tick++;
            if (m_tick == 4 * (16 - m_zone)) begin
                m_tick = 0;
                m_cells++;
                lenv   = (track_len == '0) ? TRK : int'(track_len);
                m_addr = (m_addr + 1 >= lenv) ? 0 : m_addr + 1;
            end
        end
    endtask

    // One clock: drive ce, advance the model, check the DUT after the edge
    task automatic step();
        if (ce_gap == 0) begin
            ce     = 1'b1;
            ce_gap = $urandom_range(3, 5);
        end else begin
            ce = 1'b0;
            ce_gap--;
        end
        model_step();
        @(posedge clk);
        #1;
        chk("mem_addr",   int'(mem_addr),   m_addr);
        chk("mem_we",     int'(mem_we),     m_we);
        chk("mem_wdata",  int'(mem_wdata),  m_wdata);
        chk("rd_byte",    int'(rd_byte),    m_rd);
        chk("byte_ready", int'(byte_ready), m_br);
        chk("sync_n",     int'(sync_n),     m_sync);
        if (byte_ready) begin
            seen_q.push_back(int'(rd_byte));
            br_cnt++;
        end
        if (mem_we) we_cnt++;
        if (!sync_n && sync_prev == 1) sync_falls++;
        sync_prev = int'(sync_n);
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cell; outputs must clear immediately
    task automatic do_reset();
        reset  = 1'b1;
        ce     = 1'b0;
        ce_gap = 0;
        #1;
        chk("rst_mem_addr",   int'(mem_addr),   0);
        chk("rst_mem_we",     int'(mem_we),     0);
        chk("rst_mem_wdata",  int'(mem_wdata),  0);
        chk("rst_rd_byte",    int'(rd_byte),    0);
        chk("rst_byte_ready", int'(byte_ready), 0);
        chk("rst_sync_n",     int'(sync_n),     1);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_cells(input int n);
        int target;
        int budget;
        target = m_cells + n;
        budget = n * 64 * 8 + 50;
        while (m_cells < target && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) chk("cell_budget_expired", 0, 1);
    endtask

    task automatic load_bits(input int base, input int val);
        for (int i = 0; i < 8; i++) begin
            trk[base + i]     = val[7 - i];
            exp_trk[base + i] = val[7 - i];
        end
    endtask

    initial begin
        int pat;
        reset = 1'b0; ce = 1'b0; enable = 1'b0; mode = 1'b1;
        speed_zone = 2'd3; track_len = BW'(20); wr_byte = 8'h00;
        br_cnt = 0; we_cnt = 0; sync_falls = 0; sync_prev = 1;
        model_reset();

        // Read assembly: 0x55 then 0xA3, zone 3, 20-bit track
        load_bits(0, 'h55);
        load_bits(8, 'hA3);
        @(negedge clk);
        do_reset();
        enable = 1'b1;
        seen_q.delete();
        run_cells(16);
        chk("A_nbytes", seen_q.size(), 2);
        if (seen_q.size() >= 2) begin
            chk("A_byte0", seen_q[0], 'h55);
            chk("A_byte1", seen_q[1], 'hA3);
        end

        // SYNC: twelve ones then 01010101, zone 0
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            trk[i] = 1'b1; exp_trk[i] = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            trk[12 + i] = i[0]; exp_trk[12 + i] = i[0];
        end
        speed_zone = 2'd0;
        enable = 1'b1;
        seen_q.delete();
        sync_falls = 0; sync_prev = 1;
        run_cells(20);
        chk("B_sync_episodes", sync_falls, 1);
        chk("B_nbytes", seen_q.size(), 2);
        if (seen_q.size() >= 2) begin
            chk("B_byte_before_sync", seen_q[0], 'hFF);
            chk("B_byte_after_sync",  seen_q[1], 'h55);
        end

        // Write 0xC3 repeatedly, zone 1
        enable = 1'b0;
        do_reset();
        mode = 1'b0; wr_byte = 8'hC3; speed_zone = 2'd1;
        enable = 1'b1;
        br_cnt = 0; we_cnt = 0;
        run_cells(16);
        chk("C_nbr", br_cnt, 2);
        chk("C_nwe", we_cnt, 16);
        pat = 'hC3;
        for (int i = 0; i < 16; i++)
            chk($sformatf("C_trk%0d", i), int'(trk[i]), (pat >> (7 - (i % 8))) & 1);

        // Enable dropped mid-cell for 500 clk
        speed_zone = 2'd2;
        repeat (40) step();
        enable = 1'b0;
        we_cnt = 0;
        repeat (500) step();
        chk("D_addr_frozen", int'(mem_addr), 16);
        chk("D_no_we", we_cnt, 0);
        enable = 1'b1;
        run_cells(3);

        // Randomized traffic with a biased-to-ones track
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            trk[i]     = ($urandom_range(0, 3) != 0);
            exp_trk[i] = trk[i];
        end
        mode = 1'b1; track_len = BW'(33); enable = 1'b1;
        begin
            int en_hold;
            en_hold = 0;
            for (int cyc = 0; cyc < 14000; cyc++) begin
                if (cyc == 7000) do_reset();
                if (en_hold > 0) begin
                    en_hold--;
                    if (en_hold == 0) enable = 1'b1;
                end else if ($urandom_range(0, 399) == 0) begin
                    enable  = 1'b0;
                    en_hold = $urandom_range(1, 200);
                end
                if ($urandom_range(0, 2499) == 0) mode = ~mode;
                if ($urandom_range(0, 299) == 0) speed_zone = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 49) == 0) wr_byte = 8'($urandom);
                if ($urandom_range(0, 1999) == 0)
                    track_len = ($urandom_range(0, 9) == 0) ? '0 : BW'($urandom_range(3, 40));
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
